// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 4-digit multiplexed 7-segment driver.
//   state_t   scan FSM state (SHOW / BLANK)
//   IDX_*     digit slot indices, 0 = rightmost (minute units) .. 3 = leftmost (hour tens)
//   SEG_*     active-low segment patterns, bit order {g,f,e,d,c,b,a}
package seg7_pkg;
  typedef enum logic {SHOW, BLANK} state_t;
  localparam logic [1:0] IDX_MIN_R = 2'd0;
  localparam logic [1:0] IDX_MIN_L = 2'd1;
  localparam logic [1:0] IDX_HR_R  = 2'd2;
  localparam logic [1:0] IDX_HR_L  = 2'd3;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to active-low 7-segment pattern.
//   digit  in  4  BCD value; 10..15 decode to all segments off
//   seg    out 7  active-low {g,f,e,d,c,b,a}
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans HH.MM BCD digits onto a 4-digit common-anode 7-segment display
// with a blanking dead time between slots and a once-per-frame input snapshot.
//   clk_i, rst_i (async, active-high)
//   hr_left_i, hr_right_i, min_left_i, min_right_i  BCD digits in
//   an_o   active-low anodes, [0]=min_right .. [3]=hr_left
//   seg_o  active-low segments {g,f,e,d,c,b,a}
//   dp_o   active-low decimal point, lit on the hour-units digit
// Optional: define DP_BLINK_EN to blink the decimal point at 1 Hz, 50% duty.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1_000,
  parameter int BLANK_CYCLES = 1_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] hr_left_i,
  input  logic [3:0] hr_right_i,
  input  logic [3:0] min_left_i,
  input  logic [3:0] min_right_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);
  localparam int SLOT = CLK_HZ / REFRESH_HZ;
  localparam int TW   = (SLOT < 2) ? 1 : $clog2(SLOT);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(SLOT - BLANK_CYCLES - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
  // A zero-length blank would let adjacent anodes overlap and cannot be timed by this FSM.
  if (SLOT < 2 || BLANK_CYCLES >= SLOT || BLANK_CYCLES < 1) begin : g_param_err
    $error("seg7_scan_driver: need SLOT >= 2 and 1 <= BLANK_CYCLES < SLOT");
  end
  state_t          state;
  logic [1:0]      idx;
  logic [TW-1:0]   timer;
  logic [3:0][3:0] shadow;
  logic [6:0]      dec;
  logic            dp_phase;
  logic            last;
  assign last = timer == (state == SHOW ? SHOW_LAST : BLANK_LAST);
  seg7_decode u_decode (
    .digit(shadow[idx]),
    .seg  (dec)
  );
  // Shadow only reloads when the scan wraps back to digit 0, so a frame never mixes
  // digits from before and after a carry ripple in the upstream clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= BLANK;
      idx    <= IDX_HR_L;
      timer  <= '0;
      shadow <= '0;
    end else if (last) begin
      timer <= '0;
      state <= state == SHOW ? BLANK : SHOW;
      if (state == BLANK) begin
        idx <= idx + 2'd1;
        if (idx == IDX_HR_L) shadow <= {hr_left_i, hr_right_i, min_left_i, min_right_i};
      end
    end else begin
      timer <= timer + 1'b1;
    end
  end
`ifdef DP_BLINK_EN
  localparam int HALF = (CLK_HZ / 2 < 1) ? 1 : CLK_HZ / 2;
  localparam int BW   = $clog2(HALF + 1);
  logic [BW-1:0] blink_cnt;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blink_cnt <= '0;
      dp_phase  <= 1'b1;
    end else if (blink_cnt == BW'(HALF - 1)) begin
      blink_cnt <= '0;
      dp_phase  <= ~dp_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  assign dp_phase = 1'b1;
`endif
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      an_o  <= 4'b1111;
      seg_o <= SEG_BLANK;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= state == SHOW ? ~(4'b0001 << idx) : 4'b1111;
      seg_o <= state == SHOW ? dec : SEG_BLANK;
      dp_o  <= ~(state == SHOW && idx == IDX_HR_R && dp_phase);
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver (SLOT=10, blank=2).
module tb_seg7_scan_driver;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] hr_left_i, hr_right_i, min_left_i, min_right_i;
  logic [3:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;
  int tests = 0;
  int fails = 0;
  logic [3:0] prev_an = 4'hF;

  seg7_scan_driver #(.CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .hr_left_i(hr_left_i), .hr_right_i(hr_right_i),
    .min_left_i(min_left_i), .min_right_i(min_right_i),
    .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("onehot_anode", 32'($onehot0(~an_o)), 32'd1);
      chk("adjacent_anodes", 32'(prev_an != 4'hF && an_o != 4'hF && an_o != prev_an), 32'd0);
    end
    prev_an = an_o;
  end

  task automatic set_in(input logic [3:0] hl, hr, ml, mr);
    hr_left_i = hl; hr_right_i = hr; min_left_i = ml; min_right_i = mr;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"}, 32'(an_o), 32'hF);
    chk({tag, "_seg"}, 32'(seg_o), 32'h7F);
    chk({tag, "_dp"}, 32'(dp_o), 32'd1);
  endtask

  task automatic release_rst(input string tag);
    int n;
    @(negedge clk_i);
    rst_i = 1'b0;
    n = 0;
    while (an_o === 4'hF && n < 6) begin @(negedge clk_i); n++; end
    chk({tag, "_first_latency_le3"}, 32'(n <= 3), 32'd1);
    chk({tag, "_first_an"}, 32'(an_o), 32'hE);
  endtask

  task automatic slot(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    int n;
    n = 0;
    while (an_o === 4'hF && n < 20) begin @(negedge clk_i); n++; end
    chk({tag, "_an"}, 32'(an_o), 32'(ea));
    chk({tag, "_seg"}, 32'(seg_o), 32'(es));
    chk({tag, "_dp"}, 32'(dp_o), 32'(ed));
    n = 0;
    while (an_o === ea && n < 20) begin @(negedge clk_i); n++; end
    chk({tag, "_show_len"}, 32'(n), 32'd8);
    n = 0;
    while (an_o === 4'hF && n < 20) begin @(negedge clk_i); n++; end
    chk({tag, "_blank_len"}, 32'(n), 32'd2);
  endtask

  initial begin
    set_in(4'd1, 4'd2, 4'd3, 4'd4);
    repeat (3) @(negedge clk_i);
    chk_reset("reset");
    release_rst("r0");
    slot("a0", 4'b1110, 7'b0011001, 1'b1);
    slot("a1", 4'b1101, 7'b0110000, 1'b1);
    slot("a2", 4'b1011, 7'b0100100, 1'b0);
    slot("a3", 4'b0111, 7'b1111001, 1'b1);
    slot("b0", 4'b1110, 7'b0011001, 1'b1);
    set_in(4'd1, 4'd3, 4'd0, 4'd0);
    slot("b1_old", 4'b1101, 7'b0110000, 1'b1);
    slot("b2_old", 4'b1011, 7'b0100100, 1'b0);
    slot("b3_old", 4'b0111, 7'b1111001, 1'b1);
    slot("c0_new", 4'b1110, 7'b1000000, 1'b1);
    min_right_i = 4'd10;
    slot("c1", 4'b1101, 7'b1000000, 1'b1);
    slot("c2", 4'b1011, 7'b0110000, 1'b0);
    slot("c3", 4'b0111, 7'b1111001, 1'b1);
    slot("d0_ten", 4'b1110, 7'h7F, 1'b1);
    slot("d1", 4'b1101, 7'b1000000, 1'b1);
    slot("d2", 4'b1011, 7'b0110000, 1'b0);
    slot("d3", 4'b0111, 7'b1111001, 1'b1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk_reset("midslot_reset");
    set_in(4'd9, 4'd8, 4'd7, 4'd6);
    repeat (2) @(negedge clk_i);
    chk_reset("midslot_hold");
    release_rst("r1");
    slot("e0", 4'b1110, 7'b0000010, 1'b1);
    slot("e1", 4'b1101, 7'b1111000, 1'b1);
    slot("e2", 4'b1011, 7'b0000000, 1'b0);
    slot("e3", 4'b0111, 7'b0010000, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
